pctrl_tx: RTL and testbench



---
 rtl/pctrl_tx_if.sv | 42 ++++
 rtl/pctrl_tx.sv | 140 ++++++++++++++
 tb/tb_pctrl_tx.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pctrl_tx_if.sv
// ----------------------------------------------------------------------------
// pctrl_tx_if
// Command handshake between a command source and the pctrl serial transmitter.
//
// Signals:
//   valid    source -> tx   command offered this cycle
//   ready    tx -> source   transmitter can accept a command this cycle
//   address  source -> tx   target address   (ADDR_W bits)
//   opcode   source -> tx   operation code   (OP_W bits)
//   data     source -> tx   payload          (DATA_W bits)
//
// Modports:
//   master   command source (drives valid and the fields, observes ready)
//   slave    transmitter    (observes valid and the fields, drives ready)
// ----------------------------------------------------------------------------
interface pctrl_tx_if #(
    parameter int ADDR_W = 8,
    parameter int OP_W   = 3,
    parameter int DATA_W = 62
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] address;
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output address,
        output opcode,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  address,
        input  opcode,
        input  data,
        output ready
    );
endinterface

// File: rtl/pctrl_tx.sv
// ----------------------------------------------------------------------------
// pctrl_tx
// Serial packet transmitter: the sending end of the pctrl receive protocol.
// Accepts one {address, opcode, data} command through a valid/ready handshake
// and shifts it out on tx, one bit per clk, MSB first:
//   start bit (0), address, opcode, data
// followed by at least GAP idle cycles (tx = 1).
//
// Ports:
//   clk    input   system clock; one serial bit per period
//   nrst   input   asynchronous, active-high reset (asserted when 1)
//   cmd    slave   command handshake (valid, ready, address, opcode, data)
//   tx     output  serial line, idles at 1 (registered)
//   busy   output  frame or gap in progress (registered)
//
// Parameters:
//   ADDR_W, OP_W, DATA_W  field widths; must match the cmd interface
//   GAP                   idle cycles after the data LSB, legal range 1..15
// ----------------------------------------------------------------------------
module pctrl_tx #(
    parameter int ADDR_W = 8,
    parameter int OP_W   = 3,
    parameter int DATA_W = 62,
    parameter int GAP    = 2
) (
    input  logic       clk,
    input  logic       nrst,
    pctrl_tx_if.slave  cmd,
    output logic       tx,
    output logic       busy
);

    localparam int FRAME   = 1 + ADDR_W + OP_W + DATA_W;
    // The start bit is driven directly, so only the fields need shifting.
    localparam int SHIFT_W = FRAME - 1;
    localparam int CNT_MAX = (FRAME > GAP) ? FRAME : GAP;
    localparam int CNT_W   = ($clog2(CNT_MAX + 1) > 7) ? $clog2(CNT_MAX + 1) : 7;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME - 1);
    localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             state_reg,  state_next;
    logic [CNT_W-1:0]   cnt_reg,    cnt_next;
    logic [SHIFT_W-1:0] shift_reg,  shift_next;
    logic               tx_reg,     tx_next;
    logic               ready_reg,  ready_next;
    logic               busy_reg,   busy_next;
    logic               accept;

    assign accept    = cmd.valid && ready_reg;
    assign cmd.ready = ready_reg;
    assign tx        = tx_reg;
    assign busy      = busy_reg;

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
            ready_reg <= ready_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        ready_next = ready_reg;
        busy_next  = busy_reg;

        unique case (state_reg)
            ST_IDLE: begin
                // ready rises here on the first edge after reset release,
                // and stays up until a command is taken.
                tx_next    = 1'b1;
                ready_next = 1'b1;
                busy_next  = 1'b0;
                if (accept) begin
                    shift_next = {cmd.address, cmd.opcode, cmd.data};
                    tx_next    = 1'b0;
                    ready_next = 1'b0;
                    busy_next  = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                // cnt_reg counts field bits already placed on tx; once all
                // FRAME-1 are out, the line returns high and the gap begins.
                if (cnt_reg == LAST_BIT) begin
                    tx_next    = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_GAP;
                end else begin
                    tx_next    = shift_reg[SHIFT_W-1];
                    shift_next = {shift_reg[SHIFT_W-2:0], 1'b0};
                    cnt_next   = cnt_reg + CNT_W'(1);
                end
            end

            ST_GAP: begin
                tx_next = 1'b1;
                if (cnt_reg == LAST_GAP) begin
                    ready_next = 1'b1;
                    busy_next  = 1'b0;
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                tx_next    = 1'b1;
                ready_next = 1'b0;
                busy_next  = 1'b0;
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pctrl_tx.sv
// ----------------------------------------------------------------------------
// tb_pctrl_tx
// Directed bench for pctrl_tx. Each transmitted frame is deserialised from tx
// one bit per clk and compared against the frame built from the command that
// was sent. A small receiver model (own address 8'hAA) keeps the last opcode
// addressed to it, standing in for a pctrl instance on the loopback path.
// ----------------------------------------------------------------------------
module tb_pctrl_tx;

    localparam int ADDR_W = 8;
    localparam int OP_W   = 3;
    localparam int DATA_W = 62;
    localparam int GAP    = 2;
    localparam int FRAME  = 1 + ADDR_W + OP_W + DATA_W;

    logic clk = 1'b0;
    logic nrst;
    logic tx;
    logic busy;

    pctrl_tx_if #(.ADDR_W(ADDR_W), .OP_W(OP_W), .DATA_W(DATA_W)) ifc ();

    pctrl_tx #(
        .ADDR_W (ADDR_W),
        .OP_W   (OP_W),
        .DATA_W (DATA_W),
        .GAP    (GAP)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .cmd  (ifc.slave),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    logic [2:0] rx_op   = 3'd0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Offer a command and wait for the accepting edge; returns at the negedge
    // of the start-bit cycle. With hold set, valid stays asserted.
    task automatic send(input logic [ADDR_W-1:0] a, input logic [OP_W-1:0] o,
                        input logic [DATA_W-1:0] d, input bit hold);
        int n;
        ifc.valid   = 1'b1;
        ifc.address = a;
        ifc.opcode  = o;
        ifc.data    = d;
        n = 0;
        while (ifc.ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("ready_timeout", {127'd0, ifc.ready}, 128'd1);
        @(negedge clk);
        if (!hold) ifc.valid = 1'b0;
    endtask

    // Called at the negedge of a start-bit cycle. Samples the whole frame,
    // then the gap, then the cycle where ready returns. pulse_at >= 0 offers
    // a stray command during that bit of the frame.
    task automatic expect_frame(input string tag, input logic [ADDR_W-1:0] a,
                                input logic [OP_W-1:0] o, input logic [DATA_W-1:0] d,
                                input int pulse_at, output int start);
        logic [FRAME-1:0] exp_f;
        logic [FRAME-1:0] got_f;
        logic             rdy_any;
        logic             busy_all;
        exp_f    = {1'b0, a, o, d};
        got_f    = '0;
        rdy_any  = 1'b0;
        busy_all = 1'b1;
        start    = cyc;
        for (int i = 0; i < FRAME; i++) begin
            got_f    = {got_f[FRAME-2:0], tx};
            rdy_any  = rdy_any | ifc.ready;
            busy_all = busy_all & busy;
            if (pulse_at >= 0 && i == pulse_at) begin
                ifc.valid   = 1'b1;
                ifc.address = 8'h11;
                ifc.opcode  = 3'd2;
                ifc.data    = 62'd5;
            end
            if (pulse_at >= 0 && i == pulse_at + 1) ifc.valid = 1'b0;
            @(negedge clk);
        end
        chk({tag, "_frame"}, 128'(got_f), 128'(exp_f));
        chk({tag, "_ready_in_frame"}, 128'(rdy_any), 128'd0);
        chk({tag, "_busy_in_frame"}, 128'(busy_all), 128'd1);
        for (int g = 0; g < GAP; g++) begin
            chk({tag, "_gap_tx"}, 128'(tx), 128'd1);
            chk({tag, "_gap_ready"}, 128'(ifc.ready), 128'd0);
            chk({tag, "_gap_busy"}, 128'(busy), 128'd1);
            @(negedge clk);
        end
        chk({tag, "_ready_after"}, 128'(ifc.ready), 128'd1);
        chk({tag, "_busy_after"}, 128'(busy), 128'd0);
        chk({tag, "_tx_after"}, 128'(tx), 128'd1);
        if (got_f[FRAME-2 -: ADDR_W] == 8'hAA) rx_op = got_f[DATA_W +: OP_W];
        $display("frame %s: addr=%02h op=%0d data=%016h start_cyc=%0d", tag,
                 got_f[FRAME-2 -: ADDR_W], got_f[DATA_W +: OP_W], got_f[DATA_W-1:0], start);
    endtask

    // tx must stay idle for n cycles (nothing queued or retransmitted).
    task automatic expect_quiet(input string tag, input int n);
        int zeros;
        zeros = 0;
        for (int i = 0; i < n; i++) begin
            if (tx !== 1'b1) zeros++;
            @(negedge clk);
        end
        chk({tag, "_quiet"}, 128'(zeros), 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s1, s2, s3;

        nrst        = 1'b1;
        ifc.valid   = 1'b0;
        ifc.address = '0;
        ifc.opcode  = '0;
        ifc.data    = '0;

        // Power-on reset, then a 3-cycle reset in the middle of idle.
        repeat (3) @(negedge clk);
        chk("por_tx", 128'(tx), 128'd1);
        chk("por_ready", 128'(ifc.ready), 128'd0);
        chk("por_busy", 128'(busy), 128'd0);
        nrst = 1'b0;
        @(negedge clk);
        chk("por_ready_rel", 128'(ifc.ready), 128'd1);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("rst_ready_async", 128'(ifc.ready), 128'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx", 128'(tx), 128'd1);
            chk("rst_ready", 128'(ifc.ready), 128'd0);
            chk("rst_busy", 128'(busy), 128'd0);
        end
        nrst = 1'b0;
        #1;
        chk("rel_ready_before_edge", 128'(ifc.ready), 128'd0);
        @(negedge clk);
        chk("rel_ready", 128'(ifc.ready), 128'd1);

        // Single frame; the receiver model (address AA) takes the opcode.
        send(8'hAA, 3'd4, 62'd100, 1'b0);
        expect_frame("single", 8'hAA, 3'd4, 62'd100, -1, s1);
        chk("loop_op_match", 128'(rx_op), 128'd4);

        // Frame to another address: opcode at the receiver must not change.
        send(8'h55, 3'd6, 62'd100, 1'b0);
        expect_frame("other_addr", 8'h55, 3'd6, 62'd100, -1, s1);
        chk("loop_op_nomatch", 128'(rx_op), 128'd4);

        // Back to back with valid held; fields change right after accept.
        send(8'hAA, 3'd1, 62'd0, 1'b1);
        ifc.opcode = 3'd7;
        ifc.data   = 62'h3FFF_FFFF_FFFF_FFFF;
        expect_frame("b2b_first", 8'hAA, 3'd1, 62'd0, -1, s1);
        chk("b2b_op_first", 128'(rx_op), 128'd1);
        @(negedge clk);
        ifc.valid = 1'b0;
        expect_frame("b2b_second", 8'hAA, 3'd7, 62'h3FFF_FFFF_FFFF_FFFF, -1, s2);
        chk("b2b_spacing", 128'(s2 - s1), 128'd77);
        chk("b2b_op_second", 128'(rx_op), 128'd7);
        expect_quiet("b2b", 10);

        // Stray command pulsed mid-frame is ignored and never sent.
        send(8'h3C, 3'd5, 62'h1234_5678_9ABC_DEF0, 1'b0);
        expect_frame("busy_ignore", 8'h3C, 3'd5, 62'h1234_5678_9ABC_DEF0, 10, s3);
        expect_quiet("busy_ignore", 20);

        // Reset at bit 30 (a zero data bit) forces tx high without a clock.
        send(8'hAA, 3'd5, 62'd0, 1'b0);
        repeat (30) @(negedge clk);
        chk("pre_rst_tx", 128'(tx), 128'd0);
        #2 nrst = 1'b1;
        #1;
        chk("midrst_tx", 128'(tx), 128'd1);
        chk("midrst_ready", 128'(ifc.ready), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        repeat (2) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        chk("midrst_ready_rel", 128'(ifc.ready), 128'd1);
        chk("midrst_tx_rel", 128'(tx), 128'd1);
        send(8'hAA, 3'd3, 62'd1, 1'b0);
        expect_frame("after_rst", 8'hAA, 3'd3, 62'd1, -1, s3);
        chk("after_rst_op", 128'(rx_op), 128'd3);
        expect_quiet("after_rst", 5);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
